// File: rtl/ghist_queue_ctrl_pkg.sv
// ghist_queue_ctrl_pkg: shared sizes, state/id enums and the modulo-DEPTH increment.
package ghist_queue_ctrl_pkg;
  localparam int DEPTH = 40;
  localparam int AW = $clog2(DEPTH);
  localparam int DW = 72;
  typedef enum logic {INIT, RUN} state_e;
  typedef enum logic {RD_REDIRECT, RD_COMMIT} rd_id_e;
  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] i);
    return (i == AW'(DEPTH - 1)) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/ghist_queue_ctrl_if.sv
// ghist_queue_ctrl_if: queue, read-port and response signals of the ghist controller.
// GHIST_QUEUE_CTRL_PARITY_EN adds rsp_perr.
interface ghist_queue_ctrl_if;
  import ghist_queue_ctrl_pkg::*;
  logic flush, enq_valid, enq_ready, deq, empty, full, init_done;
  logic [DW-1:0] enq_data;
  logic [AW-1:0] enq_idx, head_idx, count;
  logic rd0_valid, rd0_ready, rd1_valid, rd1_ready;
  logic [AW-1:0] rd0_idx, rd1_idx;
  logic rsp_valid, rsp_id, rsp_oor;
  logic [DW-1:0] rsp_data;
`ifdef GHIST_QUEUE_CTRL_PARITY_EN
  logic rsp_perr;
`endif
  modport master (
    output flush, enq_valid, enq_data, deq, rd0_valid, rd0_idx, rd1_valid, rd1_idx,
    input enq_ready, enq_idx, head_idx, count, empty, full, init_done,
    input rd0_ready, rd1_ready, rsp_valid, rsp_id, rsp_oor, rsp_data
`ifdef GHIST_QUEUE_CTRL_PARITY_EN
    , input rsp_perr
`endif
  );
  modport slave (
    input flush, enq_valid, enq_data, deq, rd0_valid, rd0_idx, rd1_valid, rd1_idx,
    output enq_ready, enq_idx, head_idx, count, empty, full, init_done,
    output rd0_ready, rd1_ready, rsp_valid, rsp_id, rsp_oor, rsp_data
`ifdef GHIST_QUEUE_CTRL_PARITY_EN
    , output rsp_perr
`endif
  );
endinterface

// File: rtl/ghist_queue_rd_arb.sv
// ghist_queue_rd_arb: fixed-priority rd0/rd1 arbiter for the single read port plus response stage.
// GHIST_QUEUE_CTRL_PARITY_EN adds the rsp_perr check.
module ghist_queue_rd_arb import ghist_queue_ctrl_pkg::*; (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          run,
  input  logic          rd0_valid,
  input  logic [AW-1:0] rd0_idx,
  input  logic          rd1_valid,
  input  logic [AW-1:0] rd1_idx,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [DW-1:0] mem_data,
  output logic          rd0_ready,
  output logic          rd1_ready,
  output logic          r0_en,
  output logic [AW-1:0] r0_addr,
  output logic          rsp_valid,
  output logic          rsp_id,
  output logic          rsp_oor,
`ifdef GHIST_QUEUE_CTRL_PARITY_EN
  output logic          rsp_perr,
`endif
  output logic [DW-1:0] rsp_data
);
  logic acc, oor, byp;
  logic [DW-1:0] byp_data;
  rd_id_e id_q;
  assign rd0_ready = run & rd0_valid;
  assign rd1_ready = run & rd1_valid & ~rd0_valid;
  assign acc = rd0_ready | rd1_ready;
  assign r0_addr = rd0_ready ? rd0_idx : rd1_idx;
  assign oor = r0_addr >= AW'(DEPTH);
  assign r0_en = acc & ~oor;
  // Same-index write this cycle: return the new word whatever the macro's read-during-write mode.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_oor <= 1'b0;
      id_q <= RD_REDIRECT;
      byp <= 1'b0;
      byp_data <= '0;
    end else begin
      rsp_valid <= acc;
      rsp_oor <= acc & oor;
      id_q <= rd1_ready ? RD_COMMIT : RD_REDIRECT;
      byp <= r0_en & wr_en & (wr_addr == r0_addr);
      byp_data <= wr_data;
    end
  assign rsp_id = id_q;
  assign rsp_data = (!rsp_valid || rsp_oor) ? '0 : byp ? byp_data : mem_data;
`ifdef GHIST_QUEUE_CTRL_PARITY_EN
  assign rsp_perr = ^rsp_data;
`endif
endmodule

// File: rtl/ghist_queue_ctrl.sv
// ghist_queue_ctrl: circular queue of ghist snapshots over a 40x72 two-port memory, with zero sweep after reset.
// GHIST_QUEUE_CTRL_PARITY_EN stores even parity of bits [DW-2:0] in bit DW-1 and flags read errors.
module ghist_queue_ctrl import ghist_queue_ctrl_pkg::*; (
  input  logic          clock,
  input  logic          reset_n,
  ghist_queue_ctrl_if.slave bus,
  output logic [AW-1:0] mem_R0_addr,
  output logic          mem_R0_en,
  input  logic [DW-1:0] mem_R0_data,
  output logic [AW-1:0] mem_W0_addr,
  output logic          mem_W0_en,
  output logic [DW-1:0] mem_W0_data
);
  state_e state;
  logic sweeping, run, enq_fire, deq_fire;
  logic [AW-1:0] ptr, head, tail, count;
  logic [DW-1:0] wdata;
  // Sweep enable is a register so the write port stays idle while reset is held.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= INIT;
      sweeping <= 1'b0;
      ptr <= '0;
    end else if (state == INIT) begin
      sweeping <= !(sweeping && ptr == AW'(DEPTH - 1));
      ptr <= sweeping ? wrap_inc(ptr) : ptr;
      state <= (sweeping && ptr == AW'(DEPTH - 1)) ? RUN : INIT;
    end
  assign run = state == RUN;
  assign bus.init_done = run;
  assign bus.full = count == AW'(DEPTH);
  assign bus.empty = count == '0;
  assign bus.enq_ready = run & ~bus.full & ~bus.flush;
  assign bus.enq_idx = tail;
  assign bus.head_idx = head;
  assign bus.count = count;
  assign enq_fire = bus.enq_valid & bus.enq_ready;
  assign deq_fire = bus.deq & ~bus.empty & ~bus.flush;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else if (run && bus.flush) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      tail <= enq_fire ? wrap_inc(tail) : tail;
      head <= deq_fire ? wrap_inc(head) : head;
      count <= count + AW'(enq_fire) - AW'(deq_fire);
    end
`ifdef GHIST_QUEUE_CTRL_PARITY_EN
  assign wdata = {^bus.enq_data[DW-2:0], bus.enq_data[DW-2:0]};
`else
  assign wdata = bus.enq_data;
`endif
  assign mem_W0_en = sweeping | enq_fire;
  assign mem_W0_addr = sweeping ? ptr : tail;
  assign mem_W0_data = sweeping ? '0 : wdata;
  ghist_queue_rd_arb u_arb (
    .clock(clock),
    .reset_n(reset_n),
    .run(run),
    .rd0_valid(bus.rd0_valid),
    .rd0_idx(bus.rd0_idx),
    .rd1_valid(bus.rd1_valid),
    .rd1_idx(bus.rd1_idx),
    .wr_en(mem_W0_en),
    .wr_addr(mem_W0_addr),
    .wr_data(mem_W0_data),
    .mem_data(mem_R0_data),
    .rd0_ready(bus.rd0_ready),
    .rd1_ready(bus.rd1_ready),
    .r0_en(mem_R0_en),
    .r0_addr(mem_R0_addr),
    .rsp_valid(bus.rsp_valid),
    .rsp_id(bus.rsp_id),
    .rsp_oor(bus.rsp_oor),
`ifdef GHIST_QUEUE_CTRL_PARITY_EN
    .rsp_perr(bus.rsp_perr),
`endif
    .rsp_data(bus.rsp_data)
  );
endmodule

// File: tb/tb_ghist_queue_ctrl.sv
// tb_ghist_queue_ctrl: cycle model of queue state plus a response scoreboard against a behavioural memory.
module tb_ghist_queue_ctrl;
  import ghist_queue_ctrl_pkg::*;
  logic clock = 1'b0, reset_n = 1'b0;
  always #5 clock = ~clock;
  ghist_queue_ctrl_if bus();
  logic [AW-1:0] r0_addr, w0_addr;
  logic r0_en, w0_en;
  logic [DW-1:0] r0_data, w0_data;
  ghist_queue_ctrl dut (
    .clock(clock), .reset_n(reset_n), .bus(bus.slave),
    .mem_R0_addr(r0_addr), .mem_R0_en(r0_en), .mem_R0_data(r0_data),
    .mem_W0_addr(w0_addr), .mem_W0_en(w0_en), .mem_W0_data(w0_data)
  );
  logic [DW-1:0] mem [0:63];
  logic [AW-1:0] raddr_q = '0;
  logic flip_next = 1'b0, flip_q = 1'b0;
  always @(posedge clock) begin
    if (w0_en) mem[w0_addr] <= w0_data;
    if (r0_en) raddr_q <= r0_addr;
    flip_q <= flip_next;
  end
  assign r0_data = mem[raddr_q] ^ DW'(flip_q);

  int n_cmp = 0, n_err = 0;
  typedef struct {logic id; logic oor; logic perr; logic [DW-1:0] data;} exp_t;
  exp_t sb[$];
  logic [DW-1:0] shadow [0:DEPTH-1];
  int m_head = 0, m_tail = 0, m_count = 0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mkword(input logic [DW-1:0] d);
`ifdef GHIST_QUEUE_CTRL_PARITY_EN
    return {^d[DW-2:0], d[DW-2:0]};
`else
    return d;
`endif
  endfunction

  function automatic logic [DW-1:0] rnd();
    return {8'($urandom), $urandom, $urandom};
  endfunction

  always @(negedge clock)
    if (reset_n && bus.rsp_valid) begin
      exp_t e;
      chk("rsp_pending", DW'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_oor", bus.rsp_oor, e.oor);
        chk("rsp_data", bus.rsp_data, e.data);
`ifdef GHIST_QUEUE_CTRL_PARITY_EN
        chk("rsp_perr", bus.rsp_perr, e.perr);
`endif
      end
    end

  task automatic idle_inputs();
    bus.enq_valid = 0; bus.enq_data = '0; bus.deq = 0; bus.flush = 0;
    bus.rd0_valid = 0; bus.rd0_idx = '0; bus.rd1_valid = 0; bus.rd1_idx = '0;
  endtask

  // One clock: drive, check every observable against the model at negedge, advance the model.
  task automatic cyc(input logic ev, input logic [DW-1:0] d, input logic dq, input logic fl,
                     input logic v0, input int i0, input logic v1, input int i1);
    logic [DW-1:0] w;
    logic acc_e, deq_e;
    int ri;
    exp_t e;
    bus.enq_valid = ev; bus.enq_data = d; bus.deq = dq; bus.flush = fl;
    bus.rd0_valid = v0; bus.rd0_idx = AW'(i0); bus.rd1_valid = v1; bus.rd1_idx = AW'(i1);
    w = mkword(d);
    acc_e = ev && m_count < DEPTH && !fl;
    deq_e = dq && m_count > 0 && !fl;
    @(negedge clock);
    chk("count", bus.count, m_count);
    chk("head_idx", bus.head_idx, m_head);
    chk("enq_idx", bus.enq_idx, m_tail);
    chk("full", bus.full, m_count == DEPTH);
    chk("empty", bus.empty, m_count == 0);
    chk("enq_ready", bus.enq_ready, m_count < DEPTH && !fl);
    chk("w0_en", w0_en, acc_e);
    if (acc_e) begin
      chk("w0_addr", w0_addr, m_tail);
      chk("w0_data", w0_data, w);
    end
    chk("rd0_ready", bus.rd0_ready, v0);
    chk("rd1_ready", bus.rd1_ready, v1 && !v0);
    if (v0 || v1) begin
      ri = v0 ? i0 : i1;
      chk("r0_en", r0_en, ri < DEPTH);
      if (ri < DEPTH) chk("r0_addr", r0_addr, ri);
      e.id = !v0;
      e.oor = ri >= DEPTH;
      e.perr = flip_next && !e.oor;
      e.data = e.oor ? '0 : (acc_e && ri == m_tail) ? w : shadow[ri];
      if (e.perr) e.data = e.data ^ DW'(1);
      sb.push_back(e);
    end else chk("r0_en_idle", r0_en, 0);
    if (fl) begin
      m_head = 0; m_tail = 0; m_count = 0;
    end else begin
      if (acc_e) begin
        shadow[m_tail] = w;
        m_tail = (m_tail + 1) % DEPTH;
      end
      if (deq_e) m_head = (m_head + 1) % DEPTH;
      m_count = m_count + int'(acc_e) - int'(deq_e);
    end
    @(posedge clock); #1;
    idle_inputs();
  endtask

  // Traffic held high through the sweep must be refused until init_done.
  task automatic sweep_chk();
    int w = 0;
    bus.enq_valid = 1; bus.rd0_valid = 1; bus.flush = 1;
    for (int c = 0; c < 80; c++) begin
      @(negedge clock);
      if (bus.init_done) break;
      chk("sweep_enq_ready", bus.enq_ready, 0);
      chk("sweep_rd0_ready", bus.rd0_ready, 0);
      if (w0_en) begin
        chk("sweep_addr", w0_addr, w);
        chk("sweep_data", w0_data, 0);
        w++;
      end
    end
    idle_inputs();
    chk("sweep_writes", w, DEPTH);
    chk("init_done", bus.init_done, 1);
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    m_head = 0; m_tail = 0; m_count = 0;
    @(posedge clock); #1;
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_enq_ready"}, bus.enq_ready, 0);
    chk({tag, "_rd0_ready"}, bus.rd0_ready, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_init_done"}, bus.init_done, 0);
    chk({tag, "_count"}, bus.count, 0);
    chk({tag, "_head"}, bus.head_idx, 0);
    chk({tag, "_w0_en"}, w0_en, 0);
    chk({tag, "_r0_en"}, r0_en, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    bus.rd0_valid = 1;
    repeat (3) @(negedge clock);
    reset_chk("rst");
    @(posedge clock); #1;
    reset_n = 1;
    sweep_chk();
    for (int i = 0; i < DEPTH; i++) cyc(1, rnd(), 0, 0, 0, 0, 0, 0);
    cyc(1, rnd(), 0, 0, 0, 0, 0, 0);
    cyc(1, rnd(), 1, 0, 0, 0, 0, 0);
    cyc(1, rnd(), 0, 0, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 1, 5, 1, 7);
    cyc(0, '0, 0, 0, 0, 0, 1, 7);
    for (int i = 0; i < 12; i++) begin
      logic v0, v1;
      v0 = 1'($urandom_range(0, 1));
      v1 = !v0 || 1'($urandom_range(0, 1));
      cyc(0, '0, 0, 0, v0, $urandom_range(0, 63), v1, $urandom_range(0, 63));
    end
    cyc(0, '0, 0, 0, 1, 45, 0, 0);
    cyc(0, '0, 0, 0, 1, 39, 0, 40);
    cyc(0, '0, 1, 0, 0, 0, 0, 0);
    cyc(1, rnd(), 0, 0, 1, m_tail, 0, 0);
    cyc(0, '0, 0, 1, 0, 0, 0, 0);
    repeat (3) cyc(1, rnd(), 0, 0, 0, 0, 0, 0);
    cyc(1, rnd(), 1, 1, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0, 1, 10);
    cyc(0, '0, 1, 0, 0, 0, 0, 0);
`ifdef GHIST_QUEUE_CTRL_PARITY_EN
    flip_next = 1;
    cyc(0, '0, 0, 0, 1, 5, 0, 0);
    flip_next = 0;
    cyc(0, '0, 0, 0, 0, 0, 0, 0);
`endif
    cyc(1, rnd(), 0, 0, 0, 0, 0, 0);
    cyc(1, rnd(), 0, 0, 0, 0, 0, 0);
    bus.rd0_valid = 1; bus.rd0_idx = 3;
    @(posedge clock); #1;
    reset_n = 0;
    @(negedge clock);
    reset_chk("rst_mid");
    @(posedge clock); #1;
    reset_n = 1;
    sweep_chk();
    cyc(1, rnd(), 0, 0, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 1, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0, 0, 0);
    cyc(0, '0, 0, 0, 0, 0, 0, 0);
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
